// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick divider and 640x480@60 sync/coordinate generator.
// The divider, the counters and every output flag sit in registers loaded from
// the same next-state decode. Coordinates, syncs, video_on and strobes
// therefore always describe the same pixel, with no skew between them.
// Optional build macro: VGA_TIMING_FRAME_COUNT_EN adds the 8-bit frame_count
// output.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter int   CLK_DIV  = 2,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic       pix_tick,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       video_on,
   output logic       line_start,
   output logic       frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
   ,
   output logic [7:0] frame_count
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]       H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0]       V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0]       HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]       HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]       VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]       VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_reg, div_next;
   logic [9:0]       hcount_reg, hcount_next;
   logic [9:0]       vcount_reg, vcount_next;
   logic             pix_tick_reg, pix_tick_next;
   logic             vga_hs_reg, vga_hs_next;
   logic             vga_vs_reg, vga_vs_next;
   logic             video_on_reg, video_on_next;
   logic             line_start_reg, line_start_next;
   logic             frame_start_reg, frame_start_next;

   // Next-state decode. The divider parks at its last value until the pending
   // tick has been consumed by the counters, so a pause landing between the
   // tick and its consumption neither drops nor repeats a pixel.
   always_comb begin
      div_next    = div_reg;
      hcount_next = hcount_reg;
      vcount_next = vcount_reg;
      if (enable) begin
         if (pix_tick_reg) begin
            div_next = '0;
            if (hcount_reg == H_LAST) begin
               hcount_next = '0;
               vcount_next = (vcount_reg == V_LAST) ? 10'd0 : vcount_reg + 10'd1;
            end else begin
               hcount_next = hcount_reg + 10'd1;
            end
         end else if (div_reg != DIV_LAST) begin
            div_next = div_reg + 1'b1;
         end
      end
      pix_tick_next    = enable && (div_next == DIV_LAST);
      line_start_next  = enable && pix_tick_reg && (hcount_reg == H_LAST);
      frame_start_next = line_start_next && (vcount_reg == V_LAST);
      video_on_next    = enable && (hcount_next < H_VIS) && (vcount_next < V_VIS);
      vga_hs_next      = (enable && hcount_next >= HS_FIRST && hcount_next <= HS_LAST)
                         ? SYNC_POL : ~SYNC_POL;
      vga_vs_next      = (enable && vcount_next >= VS_FIRST && vcount_next <= VS_LAST)
                         ? SYNC_POL : ~SYNC_POL;
   end

   // State and registered outputs; reset drops everything to idle at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_reg         <= '0;
         hcount_reg      <= '0;
         vcount_reg      <= '0;
         pix_tick_reg    <= 1'b0;
         vga_hs_reg      <= ~SYNC_POL;
         vga_vs_reg      <= ~SYNC_POL;
         video_on_reg    <= 1'b0;
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         div_reg         <= div_next;
         hcount_reg      <= hcount_next;
         vcount_reg      <= vcount_next;
         pix_tick_reg    <= pix_tick_next;
         vga_hs_reg      <= vga_hs_next;
         vga_vs_reg      <= vga_vs_next;
         video_on_reg    <= video_on_next;
         line_start_reg  <= line_start_next;
         frame_start_reg <= frame_start_next;
      end
   end

   assign pix_tick    = pix_tick_reg;
   assign vga_hs      = vga_hs_reg;
   assign vga_vs      = vga_vs_reg;
   assign hcount      = hcount_reg;
   assign vcount      = vcount_reg;
   assign video_on    = video_on_reg;
   assign line_start  = line_start_reg;
   assign frame_start = frame_start_reg;

`ifdef VGA_TIMING_FRAME_COUNT_EN
   logic [7:0] frame_count_reg;

   // Frame counter steps on the same edge that raises frame_start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_count_reg <= 8'd0;
      end else if (frame_start_next) begin
         frame_count_reg <= frame_count_reg + 8'd1;
      end
   end

   assign frame_count = frame_count_reg;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream stage of the VGA path: derives the pixel tick from the board clock and generates 640x480@60 sync timing.
- Produces horizontal/vertical pixel coordinates, active-video flag and line/frame strobes.
- Feeds the pattern/application logic (coordinates) and the painter (video_on) directly.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (>=1)
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run; low freezes timing
- pix_tick  out  1  one-clk pulse per pixel period
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- hcount  out  10  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- video_on  out  1  high while hcount<H_ACTIVE and vcount<V_ACTIVE
- line_start  out  1  one-clk pulse when hcount wraps to 0
- frame_start  out  1  one-clk pulse when (hcount,vcount) wraps to (0,0)

Behaviour:
- Reset is asynchronous and active-low on reset; one clock, clk.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must fit in 10 bits.
- Reset values:
  - Divider = 0; hcount = 0; vcount = 0.
  - pix_tick, video_on, line_start and frame_start = 0.
  - vga_hs and vga_vs = inactive level (~SYNC_POL).
- Divider:
  - Counts 0..CLK_DIV-1 while enable=1.
  - pix_tick=1 in the cycle the divider equals CLK_DIV-1; the divider wraps to 0 on the next clk.
  - CLK_DIV=1 gives pix_tick constantly high while enabled.
- Counters advance on clk edges where pix_tick=1:
  - hcount increments.
  - At H_TOTAL-1, hcount goes to 0 and vcount increments.
  - At vcount=V_TOTAL-1 with hcount=H_TOTAL-1, both go to 0.
- All outputs are registered and coherent: vga_hs, vga_vs and video_on decode the same (hcount,vcount) pair visible on the ports in that cycle. Zero skew between coordinates and flags.
- vga_hs = SYNC_POL while H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1 (656..751); otherwise ~SYNC_POL.
- vga_vs = SYNC_POL while V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1 (490..491), for whole lines; otherwise ~SYNC_POL.
- Strobes:
  - line_start is high for exactly one clk: the first clk in which the new hcount=0 is visible.
  - frame_start is the same, for (0,0); it coincides with line_start at that point.
  - Strobes are not raised for the (0,0) position right after reset.
- enable=0:
  - Divider and counters hold their values.
  - pix_tick and strobes are forced to 0.
  - vga_hs and vga_vs are inactive; video_on=0.
- enable returning to 1 resumes from the held position; the divider restarts from its held value.
- Reset mid-frame returns immediately to the reset values; no partial pulses are emitted afterwards.

Optional Feature:
- Macro: VGA_TIMING_FRAME_COUNT_EN.
- When defined: extra output frame_count (8-bit). Reset 0; increments in the same clk frame_start is asserted; wraps 255->0; holds while enable=0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset held low 5 clks, then released with enable=1, CLK_DIV=2:
  - pix_tick pulses every 2nd clk.
  - hcount reaches 799 then 0 after 1600 clks.
  - line_start asserts for 1 clk at that wrap.
  - vcount becomes 1.
- Horizontal sync: vga_hs is low exactly for hcount 656..751 (96 pixels = 192 clks) on every line; high elsewhere.
- Vertical sync and frame length:
  - vga_vs is low only while vcount is 490 or 491 (3200 clks).
  - frame_start pulses once per 840000 clks.
  - video_on is high for exactly 640*480 pixel ticks per frame.
- Pause and resume:
  - Drop enable at hcount=300, vcount=100 for 50 clks: counters hold at 300/100, hs/vs inactive, video_on=0, no pix_tick.
  - On re-enable, counting continues from 300 with no skipped or repeated pixel.
- Reset mid-frame at vcount=491 while vga_vs is active: vga_vs goes inactive asynchronously; counters read 0/0; no frame_start is emitted on release.
- With VGA_TIMING_FRAME_COUNT_EN defined: run 257 frames; frame_count reads 1 after the 257th frame_start (wrapped through 255->0).
